// File: rtl/fetch_unit_pkg.sv
// fetch_unit_pkg: shared state encoding and PC increment for the fetch unit
package fetch_unit_pkg;
    localparam int PC_W = 16;
    localparam logic [PC_W-1:0] PC_INC = 16'd2;
    typedef enum logic [1:0] {FETCH = 2'd0, FULL = 2'd1, HALTED = 2'd2} state_t;
endpackage

// File: rtl/fetch_unit_pc_reg.sv
// pc_reg: fetch PC register with synchronous reset to RESET_PC and load enable
module pc_reg
    import fetch_unit_pkg::*;
#(
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            i_load,
    input  logic [PC_W-1:0] i_d,
    output logic [PC_W-1:0] o_q
);
    logic [PC_W-1:0] r_pc;
    // hold the fetch address; reload on sequential advance or redirect
    always_ff @(posedge clk)
        if (rst) r_pc <= RESET_PC;
        else if (i_load) r_pc <= i_d;
    assign o_q = r_pc;
endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: single-outstanding instruction fetch with redirect, halt and optional alignment check (FETCH_ALIGN_CHK_EN)
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter logic [15:0] RESET_PC = 16'h0000
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [15:0] imem_addr,
    input  logic        imem_ack,
    input  logic [15:0] imem_rdata,
    output logic [15:0] instr,
    output logic [15:0] pc_plus2,
    output logic        instr_valid,
    input  logic        instr_ready,
    input  logic        redirect_valid,
    input  logic [15:0] redirect_pc,
    input  logic        halt,
    output logic        align_err
);
    state_t      r_state, w_state_nxt;
    logic        r_bubble, r_req_q, r_drop, r_halt_pend, r_align_err;
    logic [15:0] r_instr, r_pc_plus2, r_redir_pc;
    logic [15:0] w_pc, w_pc_d, w_pc_inc, w_target, w_redir_nxt;
    logic        w_pc_ld, w_capture, w_ack, w_misalign, w_redir;
    logic        w_drop_nxt, w_halt_nxt, w_bubble_nxt;

    pc_reg #(.RESET_PC(RESET_PC)) u_pc_reg (
        .clk    (clk),
        .rst    (rst),
        .i_load (w_pc_ld),
        .i_d    (w_pc_d),
        .o_q    (w_pc)
    );

`ifdef FETCH_ALIGN_CHK_EN
    assign w_misalign = redirect_valid && redirect_pc[0];
    assign w_target   = redirect_pc;
`else
    assign w_misalign = 1'b0;
    assign w_target   = redirect_pc & 16'hFFFE;
`endif

    assign w_redir     = redirect_valid && !w_misalign;
    assign w_pc_inc    = w_pc + PC_INC;
    assign imem_req    = !rst && r_state == FETCH && !r_bubble;
    assign imem_addr   = w_pc;
    assign w_ack       = imem_req && r_req_q && imem_ack;
    assign instr       = r_instr;
    assign pc_plus2    = r_pc_plus2;
    assign instr_valid = !rst && r_state == FULL;
    assign align_err   = r_align_err;

    // next state: halt beats redirect beats ready; a request in flight always completes before leaving FETCH
    always_comb begin
        w_state_nxt  = r_state;
        w_pc_ld      = 1'b0;
        w_pc_d       = r_pc_plus2;
        w_capture    = 1'b0;
        w_drop_nxt   = r_drop;
        w_redir_nxt  = r_redir_pc;
        w_halt_nxt   = r_halt_pend;
        w_bubble_nxt = 1'b0;
        case (r_state)
            FETCH: begin
                if (w_ack) begin
                    w_bubble_nxt = 1'b1;
                    w_drop_nxt   = 1'b0;
                    if (r_halt_pend || halt || w_misalign) w_state_nxt = HALTED;
                    else if (w_redir) begin
                        w_pc_ld = 1'b1;
                        w_pc_d  = w_target;
                    end else if (r_drop) begin
                        w_pc_ld = 1'b1;
                        w_pc_d  = r_redir_pc;
                    end else begin
                        w_capture   = 1'b1;
                        w_state_nxt = FULL;
                    end
                end else if (halt || w_misalign) w_halt_nxt = 1'b1;
                else if (w_redir && !r_halt_pend) begin
                    w_drop_nxt  = 1'b1;
                    w_redir_nxt = w_target;
                end
            end
            FULL: begin
                if (halt || w_misalign) w_state_nxt = HALTED;
                else if (w_redir) begin
                    w_state_nxt = FETCH;
                    w_pc_ld     = 1'b1;
                    w_pc_d      = w_target;
                end else if (instr_ready) begin
                    w_state_nxt = FETCH;
                    w_pc_ld     = 1'b1;
                end
            end
            default: w_state_nxt = HALTED;
        endcase
    end

    // state, flags and the presented instruction
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= FETCH;
            r_bubble    <= 1'b0;
            r_req_q     <= 1'b0;
            r_drop      <= 1'b0;
            r_halt_pend <= 1'b0;
            r_align_err <= 1'b0;
            r_redir_pc  <= 16'h0000;
            r_instr     <= 16'h0000;
            r_pc_plus2  <= 16'h0000;
        end else begin
            r_state     <= w_state_nxt;
            r_bubble    <= w_bubble_nxt;
            r_req_q     <= imem_req;
            r_drop      <= w_drop_nxt;
            r_halt_pend <= w_halt_nxt;
            r_align_err <= w_misalign && r_state != HALTED && !r_halt_pend;
            r_redir_pc  <= w_redir_nxt;
            if (w_capture) begin
                r_instr    <= imem_rdata;
                r_pc_plus2 <= w_pc_inc;
            end
        end
    end
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: randomized scoreboard bench for fetch_unit (FETCH_ALIGN_CHK_EN selects the alignment-check expectations)
module tb_fetch_unit;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        imem_req, imem_ack = 1'b0;
    logic [15:0] imem_addr, imem_rdata = 16'h0000;
    logic [15:0] instr, pc_plus2;
    logic        instr_valid, align_err;
    logic        instr_ready = 1'b0, redirect_valid = 1'b0, halt = 1'b0;
    logic [15:0] redirect_pc = 16'h0000;

    fetch_unit #(.RESET_PC(16'h0000)) dut (
        .clk            (clk),
        .rst            (rst),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_ack       (imem_ack),
        .imem_rdata     (imem_rdata),
        .instr          (instr),
        .pc_plus2       (pc_plus2),
        .instr_valid    (instr_valid),
        .instr_ready    (instr_ready),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .halt           (halt),
        .align_err      (align_err)
    );

    always #5 clk = ~clk;

    int          n_cmp = 0, n_err = 0, n_ack = 0, lat_fix = 1;
    logic        force_ack = 1'b0, m_halted = 1'b0;
    logic [15:0] m_pc = 16'h0000;
    logic [31:0] exp_q[$];

    function automatic logic [15:0] mem_word(input logic [15:0] a);
        return (a == 16'h0000) ? 16'hC123 : (a ^ 16'h5A3C) + {a[7:0], a[15:8]};
    endfunction

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %h, required %h", nm, act, req);
        end
    endtask

    // reference model: decode next sees the word at the last redirect target, else the sequential successor
    task automatic expect_at(input logic [15:0] a);
        m_pc = a;
        exp_q.push_back({mem_word(a), a + 16'd2});
    endtask

    task automatic decode(input logic rdy, input logic rv, input logic [15:0] rpc, input logic h);
        instr_ready = rdy;
        redirect_valid = rv;
        redirect_pc = rpc;
        halt = h;
        if (!m_halted) begin
            if (h) begin
                m_halted = 1'b1;
                exp_q.delete();
            end else if (rv) begin
                exp_q.delete();
`ifdef FETCH_ALIGN_CHK_EN
                if (rpc[0]) m_halted = 1'b1;
                else expect_at(rpc);
`else
                expect_at(rpc & 16'hFFFE);
`endif
            end else if (rdy && instr_valid) expect_at(m_pc + 16'd2);
        end
    endtask

    task automatic wait_valid(input int max);
        int n = 0;
        @(negedge clk);
        while (!instr_valid && n < max) begin
            decode(0, 0, 0, 0);
            @(negedge clk);
            n++;
        end
        check("valid_timeout", 32'(instr_valid), 1);
    endtask

    task automatic do_reset(input logic late);
        @(negedge clk);
        rst = 1'b1;
        decode(0, 0, 0, 0);
        repeat (3) @(negedge clk);
        check("rst_req", 32'(imem_req), 0);
        check("rst_valid", 32'(instr_valid), 0);
        check("rst_instr", 32'(instr), 0);
        check("rst_pc_plus2", 32'(pc_plus2), 0);
        check("rst_align_err", 32'(align_err), 0);
        force_ack = late;
        @(negedge clk);
        force_ack = 1'b0;
        rst = 1'b0;
        m_halted = 1'b0;
        exp_q.delete();
        expect_at(16'h0000);
        @(negedge clk);
        check("first_req", 32'(imem_req), 1);
        check("first_addr", 32'(imem_addr), 32'h0000);
    endtask

    // memory: acks 1..3 cycles after a request is first seen, data is a fixed function of the address
    int          m_cnt = 0, m_lat = 1;
    logic [15:0] m_a0 = 16'h0000;
    always @(negedge clk) begin
        #1;
        imem_ack = 1'b0;
        if (force_ack) begin
            imem_ack = 1'b1;
            imem_rdata = 16'hDEAD;
        end else if (rst || !imem_req) m_cnt = 0;
        else begin
            m_cnt++;
            if (m_cnt == 1) begin
                m_lat = (lat_fix != 0) ? lat_fix : int'($urandom_range(1, 3));
                m_a0 = imem_addr;
            end else check("addr_stable", 32'(imem_addr), 32'(m_a0));
            if (m_cnt > m_lat) begin
                imem_ack = 1'b1;
                imem_rdata = mem_word(imem_addr);
                m_cnt = 0;
                n_ack++;
            end
        end
    end

    // monitor: each new presentation pops one expectation; held presentations must not change
    logic        prev_v = 1'b0, have_cur = 1'b0;
    logic [31:0] cur = 32'h0;
    always @(posedge clk) begin
        #1;
        if (rst) prev_v = 1'b0;
        else begin
            if (instr_valid && !prev_v) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    have_cur = 1'b0;
                    $display("FAIL unexpected_instr: got %h/%h, required no instruction", instr, pc_plus2);
                end else begin
                    cur = exp_q.pop_front();
                    have_cur = 1'b1;
                    check("instr_pc_plus2", {instr, pc_plus2}, cur);
                end
            end else if (instr_valid && have_cur) begin
                check("hold_instr", {instr, pc_plus2}, cur);
                check("hold_req", 32'(imem_req), 0);
            end
            prev_v = instr_valid;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish, required finish");
        $fatal(1);
    end

    initial begin
        int n0;
        do_reset(1'b0);
        decode(0, 0, 0, 0);
        wait_valid(20);
        decode(0, 0, 0, 0);
        repeat (5) begin
            @(negedge clk);
            decode(0, 0, 0, 0);
        end
        @(negedge clk);
        decode(1, 0, 0, 0);
        @(negedge clk);
        check("next_req", 32'(imem_req), 1);
        check("next_addr", 32'(imem_addr), 32'h0002);
        decode(0, 0, 0, 0);
        wait_valid(20);
        decode(1, 0, 0, 0);
        @(negedge clk);
        check("req_at_4", 32'(imem_addr), 32'h0004);
        lat_fix = 3;
        decode(0, 1, 16'h0040, 0);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            decode(0, 0, 0, 0);
            if (imem_req && imem_addr != 16'h0004) break;
        end
        check("redirect_addr", 32'(imem_addr), 32'h0040);
        lat_fix = 1;
        wait_valid(20);
        decode(0, 1, 16'hFFFE, 0);
        wait_valid(20);
        decode(1, 0, 0, 0);
        @(negedge clk);
        check("wrap_addr", 32'(imem_addr), 32'h0000);
        decode(0, 0, 0, 0);
        wait_valid(20);
        decode(0, 1, 16'h0011, 0);
        @(negedge clk);
`ifdef FETCH_ALIGN_CHK_EN
        check("align_err_pulse", 32'(align_err), 1);
        decode(0, 0, 0, 0);
        @(negedge clk);
        check("align_err_clear", 32'(align_err), 0);
        check("align_halt_req", 32'(imem_req), 0);
`else
        check("align_err_tied", 32'(align_err), 0);
        check("odd_redirect_addr", 32'(imem_addr), 32'h0010);
        decode(0, 0, 0, 0);
        wait_valid(20);
`endif
        do_reset(1'b1);
        lat_fix = 0;
        decode(0, 0, 0, 0);
        for (int i = 0; i < 2500; i++) begin
            int r;
            logic [15:0] rpc;
            @(negedge clk);
            r = int'($urandom_range(0, 99));
            rpc = (r < 2) ? 16'hFFFE : 16'($urandom);
`ifdef FETCH_ALIGN_CHK_EN
            rpc = rpc & 16'hFFFE;
`endif
            decode(($urandom % 4) != 0, r < 6, rpc, 0);
        end
        wait_valid(50);
        decode(1, 0, 0, 0);
        @(negedge clk);
        check("pre_halt_req", 32'(imem_req), 1);
        lat_fix = 2;
        n0 = n_ack;
        decode(0, 0, 0, 1);
        repeat (8) begin
            @(negedge clk);
            decode(0, 0, 0, 0);
        end
        check("halt_ack_done", 32'(n_ack - n0), 1);
        repeat (10) begin
            @(negedge clk);
            check("halted_req", 32'(imem_req), 0);
            check("halted_valid", 32'(instr_valid), 0);
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 SHALL have parameter RESET_PC, default 16'h0000, meaning the first fetch address after reset.
REQ-002 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-004 SHALL have port imem_req  output  1  instruction-memory request.
REQ-005 SHALL have port imem_addr  output  16  byte address of the request.
REQ-006 SHALL have port imem_ack  input  1  memory response valid.
REQ-007 SHALL have port imem_rdata  input  16  instruction word, valid with imem_ack.
REQ-008 SHALL have port instr  output  16  instruction presented to the decode stage.
REQ-009 SHALL have port pc_plus2  output  16  address of the presented instr plus 2.
REQ-010 SHALL have port instr_valid  output  1  instr and pc_plus2 are valid.
REQ-011 SHALL have port instr_ready  input  1  decode stage accepts instr this cycle.
REQ-012 SHALL have port redirect_valid  input  1  branch/jump taken; discard the current stream.
REQ-013 SHALL have port redirect_pc  input  16  new fetch address, valid with redirect_valid.
REQ-014 SHALL have port halt  input  1  halt instruction decoded.
REQ-015 SHALL have port align_err  output  1  misaligned fetch address detected.

Function
REQ-016 SHALL implement states FETCH (request outstanding), FULL (instr held) and HALTED.
REQ-017 SHALL, in FETCH, hold imem_req=1 with imem_addr stable until imem_ack; imem_ack is sampled no earlier than the cycle after imem_req rises.
REQ-018 SHALL, on imem_ack in FETCH with no pending drop, capture imem_rdata into instr, set pc_plus2=imem_addr+2 (16-bit wrap: 16'hFFFE gives 16'h0000), set instr_valid=1 and enter FULL.
REQ-019 SHALL, in FULL, keep instr, pc_plus2 and instr_valid stable and imem_req=0 until instr_ready=1.
REQ-020 SHALL, in FULL with instr_ready=1, clear instr_valid, advance the fetch PC to pc_plus2 and return to FETCH; the next request starts the following cycle, so there is one bubble per instruction.
REQ-021 SHALL, on redirect_valid in FULL, clear instr_valid, set the fetch PC to redirect_pc and enter FETCH; instr_ready is ignored in that cycle.
REQ-022 SHALL, on redirect_valid in FETCH before imem_ack, record redirect_pc, set a drop flag and keep imem_addr unchanged until the ack.
REQ-023 SHALL, on imem_ack with the drop flag set, discard imem_rdata, clear the flag and issue the next request at the recorded redirect_pc.
REQ-024 SHALL, when redirect_valid and imem_ack coincide, discard imem_rdata and fetch next at redirect_pc.
REQ-025 SHALL, on halt, give halt priority over redirect_valid and over instr_ready.
REQ-026 SHALL, on halt in FULL, clear instr_valid and enter HALTED.
REQ-027 SHALL, on halt in FETCH, wait for imem_ack, discard the data and then enter HALTED, so the memory handshake always completes.
REQ-028 SHALL, in HALTED, hold imem_req=0 and instr_valid=0 until rst.
REQ-029 SHALL keep align_err=0 unless FETCH_ALIGN_CHK_EN is defined.

Reset
REQ-030 SHALL, in the cycle rst=1, set imem_req=0, instr_valid=0, instr=16'h0000, pc_plus2=16'h0000, align_err=0, drop flag=0, fetch PC=RESET_PC and state=FETCH.
REQ-031 SHALL assert imem_req with imem_addr=RESET_PC in the first cycle after rst falls.
REQ-032 SHALL let rst abort any outstanding request; a late imem_ack that arrives in the cycle rst is asserted is ignored.

Configuration
REQ-033 SHALL, with FETCH_ALIGN_CHK_EN defined, assert align_err for one cycle, discard the redirect and enter HALTED when redirect_valid=1 and redirect_pc[0]=1.
REQ-034 SHALL, without FETCH_ALIGN_CHK_EN, tie align_err to 0 and fetch from redirect_pc with bit 0 forced to 0.

Structure
REQ-035 SHALL place the state encoding (FETCH, FULL, HALTED) and the constant 16'd2 increment in the shared CPU package.
REQ-036 SHALL instantiate one sub-module, pc_reg, a 16-bit register with synchronous reset to RESET_PC and a load enable.

Verification
REQ-037 SHALL cover reset then ack at cycle 2 with rdata 16'hC123 -> instr=16'hC123, pc_plus2=16'h0002, instr_valid=1.
REQ-038 SHALL cover instr_ready held 0 for 5 cycles -> instr stable, imem_req=0; ready=1 -> next request at 16'h0002.
REQ-039 SHALL cover redirect to 16'h0040 while a request to 16'h0004 is outstanding -> that ack's data is dropped and the next imem_addr is 16'h0040.
REQ-040 SHALL cover halt while FETCH is outstanding -> request completes, instr_valid stays 0, imem_req stays 0 thereafter.
REQ-041 SHALL cover fetch at 16'hFFFE acked -> pc_plus2=16'h0000, and the next request goes to 16'h0000.
REQ-042 SHALL cover redirect to 16'h0011 with FETCH_ALIGN_CHK_EN -> align_err pulses and the unit enters HALTED; without the macro, the next imem_addr is 16'h0010.
